// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - PC, instruction ROM and datapath signals of the Hack sequencer
interface pc_sequencer_if;
  // PC controls
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_reset;
  // instruction ROM fetch
  logic        rom_req;
  logic        rom_ready;
  logic [15:0] rom_data;
  // datapath presentation and ALU flags
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_ready;
  logic        zr;
  logic        ng;
  logic [15:0] a_reg;

  modport master (
    input  pc_out, rom_ready, rom_data, exec_ready, zr, ng, a_reg,
    output pc_in, pc_load, pc_inc, pc_reset, rom_req, instr, instr_valid
  );

  modport slave (
    output pc_out, rom_ready, rom_data, exec_ready, zr, ng, a_reg,
    input  pc_in, pc_load, pc_inc, pc_reset, rom_req, instr, instr_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Hack PC fetch/execute sequencer with halt detect, fetch timeout and retire count
module pc_sequencer #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  pc_sequencer_if.master   bus,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // The counter holds the number of ready-less FETCH cycles already seen,
  // so the last permitted cycle is the one where it equals FETCH_TIMEOUT-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [15:0]      tcnt_q;
  logic [15:0]      tcnt_d;
  logic [15:0]      instr_q;
  logic [CNT_W-1:0] retired_q;

  logic             capture;
  logic             retire;
  logic             load;
  logic             inc;
  logic             taken;
  logic             self_jump;

  assign taken = instr_q[15] &
                 ((instr_q[2] & bus.ng) |
                  (instr_q[1] & bus.zr) |
                  (instr_q[0] & ~bus.ng & ~bus.zr));

  assign self_jump = (bus.a_reg == bus.pc_out);

  always_comb begin
    state_d         = state_q;
    tcnt_d          = '0;
    capture         = 1'b0;
    retire          = 1'b0;
    load            = 1'b0;
    inc             = 1'b0;
    bus.rom_req     = 1'b0;
    bus.instr_valid = 1'b0;

    unique case (state_q)
      S_RST: begin
        state_d = S_IDLE;
      end

      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        bus.rom_req = 1'b1;
        if (bus.rom_ready) begin
          capture = 1'b1;
          state_d = S_EXEC;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      S_EXEC: begin
        bus.instr_valid = 1'b1;
        if (bus.exec_ready) begin
          retire = 1'b1;
          if (taken && self_jump) begin
            state_d = S_HALT;
          end else begin
            load    = taken;
            inc     = ~taken;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_RST;
      end
    endcase

    // Reset overrides the state decode so no PC strobe collides with pc_reset.
    if (reset) begin
      state_d = S_RST;
      tcnt_d  = '0;
      capture = 1'b0;
      retire  = 1'b0;
      load    = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_RST;
      tcnt_q    <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (capture) begin
        instr_q <= bus.rom_data;
      end
      if (retire) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_in    = bus.a_reg;
  assign bus.pc_load  = load;
  assign bus.pc_inc   = inc;
  assign bus.pc_reset = reset | (state_q == S_RST);
  assign bus.instr    = instr_q;

  assign halted    = (state_q == S_HALT);
  assign fetch_err = (state_q == S_ERR);
  assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam int CNT_W = 3;
  localparam int TO    = 4;

  typedef struct {
    logic [15:0] instr;
    int          kind;   // 0 none, 1 inc, 2 load
    logic [15:0] target;
  } exp_t;

  logic             CLK = 1'b0;
  logic             reset;
  logic             run;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] retired;

  pc_sequencer_if bus();

  pc_sequencer #(.FETCH_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .run       (run),
    .bus       (bus.master),
    .halted    (halted),
    .fetch_err (fetch_err),
    .retired   (retired)
  );

  always #5 CLK = ~CLK;

  // Environment: a Hack PC register and a small instruction ROM.
  logic [15:0] pc;
  logic [15:0] rom_mem [0:31];
  always @(posedge CLK) begin
    if (bus.pc_reset)     pc <= 16'd0;
    else if (bus.pc_load) pc <= bus.pc_in;
    else if (bus.pc_inc)  pc <= pc + 16'd1;
  end
  assign bus.pc_out   = pc;
  assign bus.rom_data = rom_mem[pc[4:0]];

  int   checks = 0;
  int   errors = 0;
  int   hs     = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];

  always @(posedge CLK) begin
    if (!reset && bus.instr_valid && bus.exec_ready) hs <= hs + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] w, input int kind, input logic [15:0] tgt);
    exp_t e;
    e.instr  = w;
    e.kind   = kind;
    e.target = tgt;
    sb.push_back(e);
  endtask

  // Monitor: strobe exclusivity every cycle, scoreboard on each retire handshake.
  always @(negedge CLK) begin
    if (mon_en) begin
      check("strobe_excl", 32'($onehot0({bus.pc_load, bus.pc_inc, bus.pc_reset})), 32'd1);
      if (!reset && bus.instr_valid && bus.exec_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got retire of %h, required none", bus.instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_instr", 32'(bus.instr), 32'(e.instr));
          check("sb_load", 32'(bus.pc_load), 32'(e.kind == 2));
          check("sb_inc", 32'(bus.pc_inc), 32'(e.kind == 1));
          if (e.kind == 2) check("sb_target", 32'(bus.pc_in), 32'(e.target));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    bus.rom_ready = 1'b1;
    bus.exec_ready = 1'b1;
    bus.zr = 1'b0;
    bus.ng = 1'b0;
    bus.a_reg = 16'd0;
    for (int i = 0; i < 32; i++) rom_mem[i] = 16'd0;
    tick();
    reset = 1'b1;
    #1;
    check("rst_pc_reset_comb", 32'(bus.pc_reset), 32'd1);
    tick();
    reset = 1'b0;
    check("rst_pc_reset_rst", 32'(bus.pc_reset), 32'd1);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check("idle_pc_reset", 32'(bus.pc_reset), 32'd0);
    check("idle_rom_req", 32'(bus.rom_req), 32'd0);
    check("idle_pc_out", 32'(bus.pc_out), 32'd0);
  endtask

  task automatic run_n(input int n);
    int start;
    int guard;
    start = hs;
    run = 1'b1;
    tick();
    guard = 0;
    while (hs < start + n - 1 && guard < 200) begin
      tick();
      guard++;
    end
    run = 1'b0;
    guard = 0;
    while (hs < start + n && guard < 200) begin
      tick();
      guard++;
    end
    check("run_n_retires", 32'(hs - start), 32'(n));
  endtask

  initial begin
    int vcount;
    int rq;
    int guard;
    logic [3:0] inc_pat;

    reset = 1'b1;
    run = 1'b0;
    bus.rom_ready = 1'b0;
    bus.exec_ready = 1'b0;
    bus.zr = 1'b0;
    bus.ng = 1'b0;
    bus.a_reg = 16'd0;
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;

    // Straight-line A then C instruction, 2-cycle latency each.
    do_reset();
    rom_mem[0] = 16'h0005;
    rom_mem[1] = 16'hEC10;
    rom_mem[2] = 16'h0005;
    push(16'h0005, 1, 16'd0);
    push(16'hEC10, 1, 16'd0);
    run = 1'b1;
    inc_pat = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      inc_pat[i] = bus.pc_inc;
      if (i == 2) check("a_pc_mid", 32'(bus.pc_out), 32'd1);
      if (i == 3) run = 1'b0;
    end
    check("a_inc_pattern", 32'(inc_pat), 32'b1010);
    tick();
    check("a_pc_end", 32'(bus.pc_out), 32'd2);
    check("a_retired", 32'(retired), 32'd2);
    check("a_rom_req_idle", 32'(bus.rom_req), 32'd0);

    // JGT taken with positive result: load a_reg.
    do_reset();
    for (int i = 0; i < 3; i++) rom_mem[i] = 16'h0003;
    rom_mem[3] = 16'hE301;
    bus.a_reg = 16'h0010;
    for (int i = 0; i < 3; i++) push(16'h0003, 1, 16'd0);
    push(16'hE301, 2, 16'h0010);
    run_n(4);
    check("b1_pc_out", 32'(bus.pc_out), 32'h0010);
    check("b1_retired", 32'(retired), 32'd4);

    // Same JGT with negative result: not taken.
    do_reset();
    for (int i = 0; i < 3; i++) rom_mem[i] = 16'h0003;
    rom_mem[3] = 16'hE301;
    bus.a_reg = 16'h0010;
    bus.ng = 1'b1;
    for (int i = 0; i < 3; i++) push(16'h0003, 1, 16'd0);
    push(16'hE301, 1, 16'd0);
    run_n(4);
    check("b2_pc_out", 32'(bus.pc_out), 32'd4);

    // Slow datapath with run dropped mid-EXEC.
    do_reset();
    rom_mem[0] = 16'h0005;
    bus.exec_ready = 1'b0;
    push(16'h0005, 1, 16'd0);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    vcount = 0;
    rq = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_valid) vcount++;
      if (bus.rom_req) rq++;
      bus.exec_ready = (vcount == 6);
      tick();
    end
    check("e_valid_cycles", 32'(vcount), 32'd6);
    check("e_rom_req", 32'(rq), 32'd0);
    check("e_pc_out", 32'(bus.pc_out), 32'd1);
    check("e_retired", 32'(retired), 32'd1);

    // ROM never ready: error after TO fetch cycles.
    do_reset();
    bus.rom_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("d_no_err_yet", 32'(fetch_err), 32'd0);
    check("d_rom_req", 32'(bus.rom_req), 32'd1);
    tick();
    check("d_fetch_err", 32'(fetch_err), 32'd1);
    check("d_err_rom_req", 32'(bus.rom_req), 32'd0);
    repeat (3) tick();
    check("d_err_sticky", 32'(fetch_err), 32'd1);

    // ROM ready on the final permitted cycle wins.
    do_reset();
    bus.rom_ready = 1'b0;
    rom_mem[0] = 16'h0005;
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.rom_ready = 1'b1;
    run = 1'b0;
    push(16'h0005, 1, 16'd0);
    tick();
    check("d2_no_err", 32'(fetch_err), 32'd0);
    check("d2_exec", 32'(bus.instr_valid), 32'd1);
    tick();
    check("d2_retired", 32'(retired), 32'd1);

    // Jump to self halts; 8 retires wrap the 3-bit counter.
    do_reset();
    for (int i = 0; i < 7; i++) rom_mem[i] = 16'h0007;
    rom_mem[7] = 16'hEA87;
    bus.a_reg = 16'h0007;
    for (int i = 0; i < 7; i++) push(16'h0007, 1, 16'd0);
    push(16'hEA87, 0, 16'd0);
    run = 1'b1;
    guard = 0;
    while (!halted && guard < 100) begin
      tick();
      guard++;
    end
    check("c_halted", 32'(halted), 32'd1);
    check("c_retired_wrap", 32'(retired), 32'd0);
    check("c_pc_out", 32'(bus.pc_out), 32'd7);
    rq = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rom_req || bus.pc_load || bus.pc_inc || !halted) rq++;
    end
    check("c_halt_quiet", 32'(rq), 32'd0);
    do_reset();

    // Reset during EXEC suppresses the pending load.
    do_reset();
    rom_mem[0] = 16'hE301;
    bus.a_reg = 16'h0010;
    run = 1'b1;
    tick();
    tick();
    check("f_in_exec", 32'(bus.instr_valid), 32'd1);
    reset = 1'b1;
    run = 1'b0;
    #1;
    check("f_no_load", 32'(bus.pc_load), 32'd0);
    check("f_no_inc", 32'(bus.pc_inc), 32'd0);
    check("f_pc_reset", 32'(bus.pc_reset), 32'd1);
    tick();
    check("f_valid_dropped", 32'(bus.instr_valid), 32'd0);
    check("f_pc_reset_rst", 32'(bus.pc_reset), 32'd1);
    reset = 1'b0;
    tick();
    check("f_idle_pc_reset", 32'(bus.pc_reset), 32'd0);
    check("f_retired", 32'(retired), 32'd0);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/execute controller for the Hack program counter. Drives the PC's reset, load, inc and in controls. Fetches each instruction from instruction ROM over a req/ready handshake, presents it to the datapath over a valid/ready handshake, and evaluates Hack jump bits against the ALU flags to choose load or increment. Sits between the PC, the instruction ROM and the CPU datapath. It also detects halt (a jump to self), flags ROM fetch timeouts and counts retired instructions.

Parameters:
FETCH_TIMEOUT, 255, max cycles rom_req may stay high without rom_ready before the error state; legal range 1..65535.
CNT_W, 32, width of the retired-instruction counter.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  level; 1 = fetch/execute enabled, 0 = stop at the next instruction boundary.
pc_out  in  16  current PC value.
pc_in  out  16  PC load value; equals a_reg at all times.
pc_load  out  1  PC load strobe.
pc_inc  out  1  PC increment strobe.
pc_reset  out  1  PC reset strobe.
rom_req  out  1  fetch request; address is pc_out.
rom_ready  in  1  ROM data valid this cycle.
rom_data  in  16  instruction word.
instr  out  16  latched instruction.
instr_valid  out  1  instr is presented to the datapath.
exec_ready  in  1  datapath has completed instr; zr and ng are valid this cycle.
zr  in  1  ALU output is zero.
ng  in  1  ALU output is negative.
a_reg  in  16  A register value, used as the jump target.
halted  out  1  jump-to-self detected.
fetch_err  out  1  ROM timeout.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Synchronous reset. While reset=1, the next state is RST and the following registers clear: instr=0, retired=0, timeout counter=0.
- pc_reset = reset OR (state==RST), combinational. This lets the PC clear on the same edge.
- States and transitions:
  - RST: pc_reset=1; all other strobes 0. Next state IDLE.
  - IDLE: all strobes 0. Goes to FETCH when run=1; otherwise stays.
  - FETCH: rom_req=1. Timeout counter increments each cycle rom_ready=0.
    - On rom_ready=1: instr<=rom_data, counter<=0, go to EXEC.
    - If counter reaches FETCH_TIMEOUT with rom_ready=0: go to ERR.
    - rom_ready arriving on the timeout cycle wins; no error.
  - EXEC: instr_valid=1, held until exec_ready=1. On the exec_ready cycle:
    - taken = instr[15] & ((instr[2]&ng) | (instr[1]&zr) | (instr[0]&~ng&~zr)).
    - If taken and a_reg==pc_out: no PC strobe, retired+1, go to HALT.
    - Else if taken: pc_load=1.
    - Else: pc_inc=1 (this covers all A-instructions, where instr[15]=0).
    - Then retired+1, and go to FETCH if run=1, else IDLE.
  - HALT: halted=1; no strobes. Leaves only on reset.
  - ERR: fetch_err=1; no strobes. Leaves only on reset.
- Strobe rules: pc_load, pc_inc and pc_reset are combinational and mutually exclusive. Each asserts for exactly one cycle per event.
- run is sampled only in IDLE and on the EXEC exit cycle. Deasserting run mid-FETCH or mid-EXEC completes the current instruction.
- Minimum instruction latency is 2 cycles: FETCH with rom_ready=1, then EXEC with exec_ready=1.
- retired wraps modulo 2^CNT_W.
- Reset in any state, including HALT and ERR: RST on the next edge, then IDLE.
- rom_ready outside FETCH and exec_ready outside EXEC are ignored.

Test Plan:
- Reset, then run=1; ROM always ready with words 0x0005 (A-instr) and 0xEC10 (C-instr, no jump); exec_ready=1 in EXEC → pc_inc pulses every 2nd cycle; pc_out goes 0,1,2; retired=2 after 4 cycles; pc_reset high exactly 1 cycle after reset.
- C-instr 0xE301 (JGT), zr=0, ng=0, a_reg=0x0010, pc_out=3 → pc_load=1 for 1 cycle with pc_in=0x0010; pc_inc=0. Same instruction with ng=1 → pc_inc=1.
- 0xEA87 (0;JMP), a_reg=pc_out=7 → halted=1 permanently, no further rom_req; then reset → pc_reset pulse, state IDLE, halted=0, retired=0.
- FETCH_TIMEOUT=4, rom_ready held 0 → fetch_err=1 after 4 FETCH cycles. rom_ready=1 on exactly the 4th cycle → no error, proceeds to EXEC.
- exec_ready delayed 5 cycles, run dropped during EXEC → instr_valid high 6 cycles, single pc_inc, return to IDLE, rom_req stays 0.
- reset asserted mid-EXEC → no pc_load or pc_inc that cycle, pc_reset=1, instr_valid=0 the next cycle.
